// File: rtl/gbuff_arbiter_pkg.sv
// Shared types and defaults for the global-buffer port-B arbiter.
// Holds the default widths and burst cap, and the requester encoding used
// for owner, last-grantee and response-tag state (IN=0, WT=1, OUT=2, NONE=3).
package gbuff_arbiter_pkg;

    localparam int unsigned DefAddrWidth = 16;
    localparam int unsigned DefWordWidth = 128;
    localparam int unsigned DefMaxBurst  = 8;

    typedef enum logic [1:0] {
        ReqIn   = 2'd0,
        ReqWt   = 2'd1,
        ReqOut  = 2'd2,
        ReqNone = 2'd3
    } req_e;

    // One-hot grant vector {OUT, WT, IN} to requester index; zero maps to NONE.
    function automatic req_e onehot_to_req(logic [2:0] oh);
        req_e r;
        if (oh[0]) begin
            r = ReqIn;
        end else if (oh[1]) begin
            r = ReqWt;
        end else if (oh[2]) begin
            r = ReqOut;
        end else begin
            r = ReqNone;
        end
        return r;
    endfunction

endpackage

// File: rtl/gbuff_arbiter_if.sv
// Bundle of requester-side and buffer-side signals around the arbiter.
//   in_*  : input-fetch read port   (req/addr in, gnt/rvalid/rdata out)
//   wt_*  : weight-fetch read port  (same shape as in_*)
//   out_* : writeback write port    (req/addr/wdata in, gnt out)
//   gb_*  : global_buffer port B    (en/we/addr/wdata out, rdata in)
// Modport slave is the arbiter's view; master is the surrounding environment.
interface gbuff_arbiter_if
    import gbuff_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned WORD_WIDTH = DefWordWidth
) ();

    logic                  in_req_i;
    logic [ADDR_WIDTH-1:0] in_addr_i;
    logic                  in_gnt_o;
    logic                  in_rvalid_o;
    logic [WORD_WIDTH-1:0] in_rdata_o;

    logic                  wt_req_i;
    logic [ADDR_WIDTH-1:0] wt_addr_i;
    logic                  wt_gnt_o;
    logic                  wt_rvalid_o;
    logic [WORD_WIDTH-1:0] wt_rdata_o;

    logic                  out_req_i;
    logic [ADDR_WIDTH-1:0] out_addr_i;
    logic [WORD_WIDTH-1:0] out_wdata_i;
    logic                  out_gnt_o;

    logic                  gb_en_o;
    logic                  gb_we_o;
    logic [ADDR_WIDTH-1:0] gb_addr_o;
    logic [WORD_WIDTH-1:0] gb_wdata_o;
    logic [WORD_WIDTH-1:0] gb_rdata_i;

    modport slave (
        input  in_req_i, in_addr_i, wt_req_i, wt_addr_i,
        input  out_req_i, out_addr_i, out_wdata_i, gb_rdata_i,
        output in_gnt_o, in_rvalid_o, in_rdata_o,
        output wt_gnt_o, wt_rvalid_o, wt_rdata_o, out_gnt_o,
        output gb_en_o, gb_we_o, gb_addr_o, gb_wdata_o
    );

    modport master (
        output in_req_i, in_addr_i, wt_req_i, wt_addr_i,
        output out_req_i, out_addr_i, out_wdata_i, gb_rdata_i,
        input  in_gnt_o, in_rvalid_o, in_rdata_o,
        input  wt_gnt_o, wt_rvalid_o, wt_rdata_o, out_gnt_o,
        input  gb_en_o, gb_we_o, gb_addr_o, gb_wdata_o
    );

endinterface

// File: rtl/gbuff_arbiter_rr_pick3.sv
// rr_pick3: 3-way round-robin priority picker.
//   req_i  : request vector {OUT, WT, IN}
//   last_i : index of the most recent grantee; search starts at last_i+1 mod 3
//   gnt_o  : one-hot grant, zero when no request is set
module gbuff_arbiter_rr_pick3 (
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [2:0] gnt_o
);

    always_comb begin
        gnt_o = 3'b000;
        case (last_i)
            2'd0: begin
                if      (req_i[1]) gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
            end
            2'd1: begin
                if      (req_i[2]) gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
            end
            // last = OUT (or the unused NONE code) restarts at IN
            default: begin
                if      (req_i[0]) gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/gbuff_arbiter.sv
// gbuff_arbiter: shares global_buffer port B among input fetch (read),
// weight fetch (read) and output writeback (write). One access per cycle,
// round-robin with a burst lock of MAX_BURST grants, and routing of the
// one-cycle-latency read data back to the requester that issued it.
//   clk_i   : clock
//   rst_n_i : synchronous active-low reset; also gates all grants low
//   bus     : requester ports and buffer port B (see gbuff_arbiter_if)
module gbuff_arbiter
    import gbuff_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = DefMaxBurst
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    gbuff_arbiter_if.slave bus
);

    localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

    req_e       r_owner;
    req_e       r_last;
    logic [7:0] r_burst_cnt;
    req_e       r_rsp_tag;

    logic [2:0] w_req;
    logic [2:0] w_own_oh;
    logic [2:0] w_rr_gnt;
    logic [2:0] w_gnt;
    logic       w_own_req;
    logic       w_others;
    logic       w_keep;
    req_e       w_grantee;

    assign w_req = {bus.out_req_i, bus.wt_req_i, bus.in_req_i};

    always_comb begin
        w_own_oh = 3'b000;
        case (r_owner)
            ReqIn:   w_own_oh = 3'b001;
            ReqWt:   w_own_oh = 3'b010;
            ReqOut:  w_own_oh = 3'b100;
            default: w_own_oh = 3'b000;
        endcase
    end

    assign w_own_req = |(w_req & w_own_oh);
    assign w_others  = |(w_req & ~w_own_oh);
    // Owner may exceed the cap only when nobody else is waiting.
    assign w_keep    = w_own_req && ((r_burst_cnt < MaxBurst) || !w_others);

    gbuff_arbiter_rr_pick3 u_rr_pick3 (
        .req_i  (w_req),
        .last_i (r_last),
        .gnt_o  (w_rr_gnt)
    );

    always_comb begin
        if (!rst_n_i) begin
            w_gnt = 3'b000;
        end else if (w_keep) begin
            w_gnt = w_own_oh;
        end else begin
            w_gnt = w_rr_gnt;
        end
    end

    assign w_grantee = onehot_to_req(w_gnt);

    assign bus.in_gnt_o  = w_gnt[0];
    assign bus.wt_gnt_o  = w_gnt[1];
    assign bus.out_gnt_o = w_gnt[2];
    assign bus.gb_en_o   = |w_gnt;
    assign bus.gb_we_o   = w_gnt[2];

    always_comb begin
        bus.gb_addr_o = '0;
        if (w_gnt[0]) begin
            bus.gb_addr_o = bus.in_addr_i;
        end else if (w_gnt[1]) begin
            bus.gb_addr_o = bus.wt_addr_i;
        end else if (w_gnt[2]) begin
            bus.gb_addr_o = bus.out_addr_i;
        end
    end

    always_comb begin
        bus.gb_wdata_o = '0;
        if (w_gnt[2]) begin
            bus.gb_wdata_o = bus.out_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_owner     <= ReqNone;
            r_last      <= ReqOut;
            r_burst_cnt <= 8'd0;
            r_rsp_tag   <= ReqNone;
        end else if (|w_gnt) begin
            r_last <= w_grantee;
            if (w_grantee == r_owner) begin
                // Saturates when the owner is kept past the cap as sole requester.
                if (r_burst_cnt < MaxBurst) begin
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                end
            end else begin
                r_owner     <= w_grantee;
                r_burst_cnt <= 8'd1;
            end
            r_rsp_tag <= (w_grantee == ReqOut) ? ReqNone : w_grantee;
        end else begin
            r_owner     <= ReqNone;
            r_burst_cnt <= 8'd0;
            r_rsp_tag   <= ReqNone;
        end
    end

    assign bus.in_rvalid_o = (r_rsp_tag == ReqIn);
    assign bus.wt_rvalid_o = (r_rsp_tag == ReqWt);
    assign bus.in_rdata_o  = bus.gb_rdata_i;
    assign bus.wt_rdata_o  = bus.gb_rdata_i;

endmodule
